// File: rtl/calcunit_multi.sv
// Segmented correlation accumulator for the stereo distance datapath: sums g, g*g and f*g
// per segment over NSEG change-delimited segments, with saturation and sticky overflow.
module calcunit_multi #(
  parameter int unsigned DW   = 3,
  parameter int unsigned NSEG = 4,
  parameter int unsigned AW   = 14,
  parameter int unsigned GW   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 valid,
  input  logic                 change,
  input  logic [DW-1:0]        fdata,
  input  logic [DW-1:0]        gdata,
  output logic [NSEG*AW-1:0]   g2sum,
  output logic [NSEG*GW-1:0]   gsum,
  output logic [NSEG*AW-1:0]   fg,
  output logic [NSEG-1:0]      ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned ASW  = ((AW > PW) ? AW : PW) + 1;
  localparam int unsigned GSW  = ((GW > DW) ? GW : DW) + 1;
  localparam int unsigned SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StAcc, StDone} state_e;

  // Stage 1: registered products
  logic [DW-1:0] p_g_q, p_g_d;
  logic [PW-1:0] p_g2_q, p_g2_d;
  logic [PW-1:0] p_fg_q, p_fg_d;
  logic          p_v_q, p_v_d;
  logic          p_c_q, p_c_d;

  // Stage 2: control and accumulators
  state_e          state_q, state_d;
  logic [SEGW-1:0] seg_q, seg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   g2_q [NSEG];
  logic [AW-1:0]   g2_d [NSEG];
  logic [AW-1:0]   fg_q [NSEG];
  logic [AW-1:0]   fg_d [NSEG];
  logic [GW-1:0]   gs_q [NSEG];
  logic [GW-1:0]   gs_d [NSEG];
  logic [NSEG-1:0] ovf_q, ovf_d;

  // Returns {overflow, clamped value}; a load starts from zero instead of the old value.
  function automatic logic [AW:0] sat_a(input logic [AW-1:0] acc, input logic [PW-1:0] p,
                                        input logic ld);
    logic [ASW-1:0] s;
    s = (ld ? ASW'(0) : ASW'(acc)) + ASW'(p);
    if (s > ASW'({AW{1'b1}})) return {1'b1, {AW{1'b1}}};
    return {1'b0, s[AW-1:0]};
  endfunction

  function automatic logic [GW:0] sat_g(input logic [GW-1:0] acc, input logic [DW-1:0] p,
                                        input logic ld);
    logic [GSW-1:0] s;
    s = (ld ? GSW'(0) : GSW'(acc)) + GSW'(p);
    if (s > GSW'({GW{1'b1}})) return {1'b1, {GW{1'b1}}};
    return {1'b0, s[GW-1:0]};
  endfunction

  always_comb begin
    p_g_d  = gdata;
    p_g2_d = {{DW{1'b0}}, gdata} * {{DW{1'b0}}, gdata};
    p_fg_d = {{DW{1'b0}}, fdata} * {{DW{1'b0}}, gdata};
    p_v_d  = valid & ~start;
    p_c_d  = change & ~start;
    if (start) begin
      p_g_d  = '0;
      p_g2_d = '0;
      p_fg_d = '0;
    end
  end

  logic            ld, add;
  logic [SEGW-1:0] tgt;
  logic [AW:0]     r_g2, r_fg;
  logic [GW:0]     r_gs;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    g2_d    = g2_q;
    fg_d    = fg_q;
    gs_d    = gs_q;
    ovf_d   = ovf_q;
    ld      = 1'b0;
    add     = 1'b0;
    tgt     = seg_q;
    r_g2    = '0;
    r_fg    = '0;
    r_gs    = '0;

    if (start) begin
      state_d = StArmed;
      seg_d   = '0;
      ovf_d   = '0;
      for (int k = 0; k < NSEG; k++) begin
        g2_d[k] = '0;
        fg_d[k] = '0;
        gs_d[k] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (p_v_q && p_c_q) begin
            ld      = 1'b1;
            tgt     = '0;
            seg_d   = '0;
            state_d = StAcc;
          end
        end
        StAcc: begin
          if (p_v_q) begin
            if (!p_c_q) begin
              add = 1'b1;
            end else if (seg_q == SEGW'(NSEG - 1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              ld    = 1'b1;
              tgt   = SEGW'(seg_q + 1'b1);
              seg_d = tgt;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    for (int k = 0; k < NSEG; k++) begin
      if ((ld || add) && (tgt == SEGW'(k))) begin
        r_g2     = sat_a(g2_q[k], p_g2_q, ld);
        r_fg     = sat_a(fg_q[k], p_fg_q, ld);
        r_gs     = sat_g(gs_q[k], p_g_q, ld);
        g2_d[k]  = r_g2[AW-1:0];
        fg_d[k]  = r_fg[AW-1:0];
        gs_d[k]  = r_gs[GW-1:0];
        ovf_d[k] = ovf_q[k] | r_g2[AW] | r_fg[AW] | r_gs[GW];
      end
    end

    busy_d = (state_d == StArmed) || (state_d == StAcc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_g_q   <= '0;
      p_g2_q  <= '0;
      p_fg_q  <= '0;
      p_v_q   <= 1'b0;
      p_c_q   <= 1'b0;
      state_q <= StIdle;
      seg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g2_q    <= '{default: '0};
      fg_q    <= '{default: '0};
      gs_q    <= '{default: '0};
      ovf_q   <= '0;
    end else begin
      p_g_q   <= p_g_d;
      p_g2_q  <= p_g2_d;
      p_fg_q  <= p_fg_d;
      p_v_q   <= p_v_d;
      p_c_q   <= p_c_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      g2_q    <= g2_d;
      fg_q    <= fg_d;
      gs_q    <= gs_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_pack
    assign g2sum[k*AW +: AW] = g2_q[k];
    assign fg[k*AW +: AW]    = fg_q[k];
    assign gsum[k*GW +: GW]  = gs_q[k];
  end

  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_calcunit_multi.sv
// Bench for calcunit_multi: scoreboarded vector table for a full frame, then hand-written
// sequences for saturation, start during accumulation and asynchronous reset.
module tb_calcunit_multi;

  localparam int unsigned DW   = 3;
  localparam int unsigned NSEG = 4;
  localparam int unsigned AW   = 14;
  localparam int unsigned GW   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                valid = 1'b0;
  logic                change = 1'b0;
  logic [DW-1:0]       fdata = '0;
  logic [DW-1:0]       gdata = '0;
  logic [NSEG*AW-1:0]  g2sum;
  logic [NSEG*GW-1:0]  gsum;
  logic [NSEG*AW-1:0]  fg;
  logic [NSEG-1:0]     ovf;
  logic                busy;
  logic                done;

  calcunit_multi #(.DW(DW), .NSEG(NSEG), .AW(AW), .GW(GW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .valid (valid),
    .change(change),
    .fdata (fdata),
    .gdata (gdata),
    .g2sum (g2sum),
    .gsum  (gsum),
    .fg    (fg),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic v;
    logic c;
    int   f;
    int   g;
    int   seg;
    int   gs;
    int   g2;
    int   fgv;
    int   ovf;
    logic busy;
    logic done;
  } vec_t;

  vec_t tbl[14];
  vec_t sb[$];
  int   ncmp = 0;
  int   nbad = 0;

  function automatic vec_t mk(int id, logic v, logic c, int f, int g, int seg, int gs, int g2,
                              int fgv, int ov, logic b, logic d);
    vec_t r;
    r.id = id; r.v = v; r.c = c; r.f = f; r.g = g; r.seg = seg;
    r.gs = gs; r.g2 = g2; r.fgv = fgv; r.ovf = ov; r.busy = b; r.done = d;
    return r;
  endfunction

  function automatic int gs_at(int k);
    return int'(gsum[k*GW +: GW]);
  endfunction
  function automatic int g2_at(int k);
    return int'(g2sum[k*AW +: AW]);
  endfunction
  function automatic int fg_at(int k);
    return int'(fg[k*AW +: AW]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_vec(input vec_t e);
    chk($sformatf("row%0d gsum[%0d]", e.id, e.seg), gs_at(e.seg), e.gs);
    chk($sformatf("row%0d g2sum[%0d]", e.id, e.seg), g2_at(e.seg), e.g2);
    chk($sformatf("row%0d fg[%0d]", e.id, e.seg), fg_at(e.seg), e.fgv);
    chk($sformatf("row%0d ovf", e.id), int'(ovf), e.ovf);
    chk($sformatf("row%0d busy", e.id), int'(busy), int'(e.busy));
    chk($sformatf("row%0d done", e.id), int'(done), int'(e.done));
  endtask

  // Each row's effect is visible two edges after it is driven.
  task automatic step(input vec_t r);
    @(negedge clk);
    if (sb.size() == 2) cmp_vec(sb.pop_front());
    valid  = r.v;
    change = r.c;
    fdata  = DW'(r.f);
    gdata  = DW'(r.g);
    sb.push_back(r);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clk);
      valid  = 1'b0;
      change = 1'b0;
      cmp_vec(sb.pop_front());
    end
  endtask

  task automatic drv(input logic v, input logic c, input int f, input int g);
    @(negedge clk);
    valid  = v;
    change = c;
    fdata  = DW'(f);
    gdata  = DW'(g);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 0, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int k = 0; k < NSEG; k++) begin
      chk($sformatf("%s gsum[%0d]", nm, k), gs_at(k), 0);
      chk($sformatf("%s g2sum[%0d]", nm, k), g2_at(k), 0);
      chk($sformatf("%s fg[%0d]", nm, k), fg_at(k), 0);
    end
    chk({nm, " ovf"}, int'(ovf), 0);
  endtask

  initial begin
    int dcount;

    //        id v  c  f  g  seg gs g2  fg  ovf busy done
    tbl[0]  = mk(0,  1, 0, 3, 3, 0, 0,  0,  0,  0, 1, 0);
    tbl[1]  = mk(1,  1, 1, 5, 3, 0, 3,  9,  15, 0, 1, 0);
    tbl[2]  = mk(2,  1, 0, 1, 2, 0, 5,  13, 17, 0, 1, 0);
    tbl[3]  = mk(3,  0, 1, 7, 7, 0, 5,  13, 17, 0, 1, 0);
    tbl[4]  = mk(4,  1, 0, 7, 7, 0, 12, 62, 66, 0, 1, 0);
    tbl[5]  = mk(5,  1, 1, 2, 1, 1, 1,  1,  2,  0, 1, 0);
    tbl[6]  = mk(6,  1, 0, 2, 2, 1, 3,  5,  6,  0, 1, 0);
    tbl[7]  = mk(7,  1, 1, 2, 1, 2, 1,  1,  2,  0, 1, 0);
    tbl[8]  = mk(8,  1, 0, 2, 2, 2, 3,  5,  6,  0, 1, 0);
    tbl[9]  = mk(9,  1, 1, 2, 1, 3, 1,  1,  2,  0, 1, 0);
    tbl[10] = mk(10, 1, 0, 2, 2, 3, 3,  5,  6,  0, 1, 0);
    tbl[11] = mk(11, 1, 1, 6, 6, 3, 3,  5,  6,  0, 0, 1);
    tbl[12] = mk(12, 1, 0, 1, 1, 0, 12, 62, 66, 0, 0, 0);
    tbl[13] = mk(13, 1, 1, 1, 1, 1, 3,  5,  6,  0, 0, 0);

    // Reset state
    #2;
    chk_all_zero("reset");
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores samples
    drv(1'b1, 1'b1, 3, 3);
    drv(1'b1, 1'b0, 3, 3);
    idle(2);
    chk("idle gsum[0]", gs_at(0), 0);
    chk("idle busy", int'(busy), 0);

    pulse_start();
    chk("start busy", int'(busy), 1);
    for (int i = 0; i < 14; i++) step(tbl[i]);
    drain();

    // Saturation of the 4-bit gsum field
    pulse_start();
    drv(1'b1, 1'b1, 1, 7);
    drv(1'b1, 1'b0, 1, 7);
    drv(1'b1, 1'b0, 1, 7);
    drv(1'b1, 1'b1, 0, 0);
    idle(2);
    chk("sat gsum[0]", gs_at(0), 15);
    chk("sat g2sum[0]", g2_at(0), 147);
    chk("sat fg[0]", fg_at(0), 21);
    chk("sat ovf", int'(ovf), 1);
    chk("sat gsum[1]", gs_at(1), 0);
    drv(1'b1, 1'b0, 3, 5);
    idle(2);
    chk("sat gsum[1] add", gs_at(1), 5);
    chk("sat fg[1] add", fg_at(1), 15);
    chk("sat ovf sticky", int'(ovf), 1);

    // start while in segment 2 with a sample in stage 1
    pulse_start();
    drv(1'b1, 1'b1, 1, 1);
    drv(1'b1, 1'b1, 1, 2);
    drv(1'b1, 1'b1, 1, 3);
    idle(2);
    chk("mid gsum[2] pre", gs_at(2), 3);
    drv(1'b1, 1'b0, 1, 4);
    @(negedge clk);
    valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_all_zero("mid start");
    chk("mid start busy", int'(busy), 1);
    idle(2);
    chk_all_zero("mid after");
    drv(1'b1, 1'b0, 1, 5);
    idle(2);
    chk("armed discard gsum[0]", gs_at(0), 0);
    drv(1'b1, 1'b1, 2, 5);
    idle(2);
    chk("armed load gsum[0]", gs_at(0), 5);
    chk("armed load fg[0]", fg_at(0), 10);

    // Asynchronous reset between edges while the frame-ending change is in flight
    drv(1'b1, 1'b1, 1, 1);
    drv(1'b1, 1'b1, 1, 1);
    drv(1'b1, 1'b1, 1, 1);
    idle(2);
    chk("pre-rst gsum[3]", gs_at(3), 1);
    drv(1'b1, 1'b1, 1, 1);
    @(posedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    chk("async rst busy", int'(busy), 0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      rst = 1'b0;
      if (done) dcount++;
    end
    chk("async rst done pulses", dcount, 0);
    chk("async rst busy after", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got time %0t, required < 50000", $time);
    $fatal(1);
  end

endmodule

// File: doc/calcunit_multi.md
Name: calcunit_multi

Overview:
- Parametrised successor to the four-window correlation accumulator in the stereo distance datapath.
- Streams paired pixel samples (f from one eye, g from the other) and accumulates Σg, Σg² and Σf·g independently for NSEG consecutive segments.
- Segment boundaries are marked by a change strobe. The result feeds the downstream distance/cost evaluator.
- New relative to the previous generation: a single clock, a registered multiply stage, per-segment saturation with sticky overflow flags, and a done/busy handshake.

Parameters:
- DW, 3, width of fdata and gdata (unsigned)
- NSEG, 4, number of segments accumulated per frame (2..16)
- AW, 14, width of each g2sum and fg accumulator
- GW, 11, width of each gsum accumulator

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  clears all accumulators, enters ARMED
- valid  in  1  sample strobe; fdata/gdata/change are sampled when high
- change  in  1  segment-boundary marker, qualified by valid
- fdata  in  DW  left-eye sample, unsigned
- gdata  in  DW  right-eye sample, unsigned
- g2sum  out  NSEG*AW  Σg² per segment; segment k is at bits [k*AW +: AW]
- gsum  out  NSEG*GW  Σg per segment; segment k is at bits [k*GW +: GW]
- fg  out  NSEG*AW  Σf·g per segment; segment k is at bits [k*AW +: AW]
- ovf  out  NSEG  sticky saturation flag per segment
- busy  out  1  high in ARMED or ACC
- done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst=1):
  - All accumulators and ovf are 0.
  - State is IDLE; busy=0, done=0.
  - Pipeline valid is cleared.
- Stage 1 (registered, every cycle):
  - p_g = gdata, p_g2 = gdata*gdata, p_fg = fdata*gdata (each product 2*DW bits).
  - p_v = valid, p_c = change.
- Stage 2:
  - Acts on p_v / p_c.
  - Latency from a sample at the input to its effect on the outputs is 2 clocks.
- States and transitions:
  - IDLE: ignores samples. start -> ARMED.
  - ARMED: p_v && !p_c is discarded. p_v && p_c loads segment 0 (acc = sample; no add) and sets seg = 0 -> ACC.
  - ACC, p_v && !p_c: acc[seg] += sample.
  - ACC, p_v && p_c with seg < NSEG-1: seg+1 is loaded with the sample; seg increments.
  - ACC, p_v && p_c with seg == NSEG-1: the sample is discarded -> DONE; done=1 for exactly that cycle.
  - DONE: accumulators hold; samples are ignored. start -> ARMED.
- start:
  - Highest priority in every state, including mid-ACC.
  - Zeroes all accumulators and ovf, clears both pipeline stages (the in-flight sample is dropped), sets state to ARMED.
  - Takes effect at the clock edge where it is sampled high; busy=1 from the next cycle.
  - start held high: the block stays in ARMED with accumulators at 0.
- Arithmetic:
  - Unsigned. Products are zero-extended to AW/GW.
  - An add whose true sum exceeds 2^AW-1 (or 2^GW-1) clamps that field to all-ones and sets ovf[seg]. Each field is clamped independently.
  - ovf clears only on start or rst.
  - A load (segment start) clamps the same way if the sample exceeds the field width. This occurs only with non-default widths.
- Segments never entered in the current frame read 0.
- Outputs are driven directly from the accumulator registers; there is no combinational path from inputs to outputs.
- valid low: the pipeline advances with p_v=0 and no accumulator changes.

Test Plan:
- Reset, then start. Send valid+change (f=5, g=3), then two valid samples (f=1, g=2) and (f=7, g=7).
  - Segment 0: gsum=12, g2sum=62, fg=66.
  - busy=1, done=0.
- Full frame, NSEG=4. Send 4 change-marked samples g=1, f=2, each followed by one plain sample g=2, f=2; then a 5th change.
  - Each segment: gsum=3, g2sum=5, fg=6.
  - done pulses once, 2 cycles after the 5th change; busy=0 afterwards.
- Samples in ARMED before the first change, and samples in DONE: no accumulator change; all segments stay 0 / hold.
- Saturation, GW=4. Load g=7, then add g=7 twice.
  - gsum[0] = 15 and ovf[0]=1.
  - The other fields are unaffected unless they also overflow.
  - ovf[0] stays set after the next change.
- Assert start mid-ACC (seg=2) with a sample in stage 1.
  - All outputs read 0 the next cycle; the in-flight sample is never added; state is ARMED.
- Assert rst asynchronously between clock edges during ACC.
  - Outputs go to 0 immediately, busy=0, and there is no done pulse.
